// File: rtl/nbank_pingpong_buffer.sv
// -----------------------------------------------------------------------------
// nbank_pingpong_buffer
//
// N-bank round-robin ping-pong buffer. It sits between a linear-projection
// output stage and a systolic core-array input. The producer fills banks in
// order (0, 1, ..., NUM_BANKS-1, 0, ...). The consumer drains completed banks
// in the same order. Each bank is replayed a per-bank number of passes before
// it is freed, which allows operand reuse across output rows.
//
// Bank life cycle: EMPTY -> FILLING (word 0 written) -> FULL (last word
// written) -> EMPTY (last word of the final pass read).
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   flush        synchronous clear of all bank state and pointers
//   cfg_reuse    pass count for the bank being written, sampled with word 0
//   wr_valid     write word valid
//   wr_ready     current write bank is EMPTY or FILLING
//   wr_data      write word
//   rd_valid     current read bank is FULL; rd_data is valid
//   rd_ready     consumer accepts rd_data
//   rd_data      read word (combinational, zero latency)
//   rd_addr      word index of rd_data within its bank
//   rd_last      rd_data is the last word of the current pass
//   rd_bank_done rd_data is the last word of the final pass; frees the bank
//   occupancy    number of banks in the FULL state
// -----------------------------------------------------------------------------
module nbank_pingpong_buffer #(
   parameter int  DATA_WIDTH = 256,
   parameter int  DEPTH      = 16,
   parameter int  NUM_BANKS  = 2,
   parameter int  MAX_REUSE  = 8,
   localparam int ADDR_W     = $clog2(DEPTH),
   localparam int REUSE_W    = $clog2(MAX_REUSE + 1),
   localparam int OCC_W      = $clog2(NUM_BANKS + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic [REUSE_W-1:0]    cfg_reuse,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic                  rd_valid,
   input  logic                  rd_ready,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic [ADDR_W-1:0]     rd_addr,
   output logic                  rd_last,
   output logic                  rd_bank_done,
   output logic [OCC_W-1:0]      occupancy
);

   localparam int                  BANK_W      = $clog2(NUM_BANKS);
   localparam logic [ADDR_W-1:0]   LAST_ADDR   = ADDR_W'(DEPTH - 1);
   localparam logic [BANK_W-1:0]   LAST_BANK   = BANK_W'(NUM_BANKS - 1);
   localparam logic [REUSE_W-1:0]  MAX_REUSE_V = REUSE_W'(MAX_REUSE);

   typedef enum logic [1:0] {
      BANK_EMPTY   = 2'd0,
      BANK_FILLING = 2'd1,
      BANK_FULL    = 2'd2
   } bank_state_t;

   // Round-robin successor; NUM_BANKS need not be a power of two.
   function automatic logic [BANK_W-1:0] bank_inc(input logic [BANK_W-1:0] b);
      return (b == LAST_BANK) ? '0 : b + 1'b1;
   endfunction

   bank_state_t            state      [NUM_BANKS];
   bank_state_t            state_next [NUM_BANKS];
   logic [REUSE_W-1:0]     reuse      [NUM_BANKS];
   logic [DATA_WIDTH-1:0]  mem        [NUM_BANKS][DEPTH];

   logic [BANK_W-1:0]      wbank;
   logic [BANK_W-1:0]      rbank;
   logic [ADDR_W-1:0]      waddr;
   logic [ADDR_W-1:0]      raddr;
   logic [REUSE_W-1:0]     pass;

   logic                   wr_fire;
   logic                   rd_fire;
   logic                   bank_fill;
   logic                   bank_free;
   logic [REUSE_W-1:0]     reuse_in;

   // ---------------------------------------------------------------------------
   // Output decode (bank FSM outputs plus read-port mux)
   // ---------------------------------------------------------------------------
   always_comb begin
      wr_ready     = (state[wbank] == BANK_EMPTY) || (state[wbank] == BANK_FILLING);
      rd_valid     = (state[rbank] == BANK_FULL);
      rd_data      = mem[rbank][raddr];
      rd_addr      = raddr;
      rd_last      = rd_valid && (raddr == LAST_ADDR);
      rd_bank_done = rd_last && (pass == reuse[rbank] - 1'b1);
   end

   assign wr_fire   = wr_valid && wr_ready;
   assign rd_fire   = rd_valid && rd_ready;
   assign bank_fill = wr_fire && (waddr == LAST_ADDR);
   assign bank_free = rd_fire && rd_bank_done;

   // Zero requests one pass; anything above MAX_REUSE saturates.
   assign reuse_in  = (cfg_reuse == '0)          ? REUSE_W'(1)  :
                      (cfg_reuse > MAX_REUSE_V)  ? MAX_REUSE_V  : cfg_reuse;

   // ---------------------------------------------------------------------------
   // Bank FSM next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every bank defaults to holding its state so no latch is inferred.
      for (int b = 0; b < NUM_BANKS; b++) state_next[b] = state[b];
      if (wr_fire) begin
         if (waddr == '0)       state_next[wbank] = BANK_FILLING;
         if (waddr == LAST_ADDR) state_next[wbank] = BANK_FULL;
      end
      // The freed bank is FULL, so it can never be the bank being written.
      if (bank_free) state_next[rbank] = BANK_EMPTY;
   end

   // ---------------------------------------------------------------------------
   // Bank FSM state register
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int b = 0; b < NUM_BANKS; b++) state[b] <= BANK_EMPTY;
      end else if (flush) begin
         for (int b = 0; b < NUM_BANKS; b++) state[b] <= BANK_EMPTY;
      end else begin
         for (int b = 0; b < NUM_BANKS; b++) state[b] <= state_next[b];
      end
   end

   // ---------------------------------------------------------------------------
   // Pointers, pass counter, per-bank reuse and occupancy
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wbank     <= '0;
         waddr     <= '0;
         rbank     <= '0;
         raddr     <= '0;
         pass      <= '0;
         occupancy <= '0;
         for (int b = 0; b < NUM_BANKS; b++) reuse[b] <= '0;
      end else if (flush) begin
         wbank     <= '0;
         waddr     <= '0;
         rbank     <= '0;
         raddr     <= '0;
         pass      <= '0;
         occupancy <= '0;
         for (int b = 0; b < NUM_BANKS; b++) reuse[b] <= '0;
      end else begin
         if (wr_fire) begin
            if (waddr == '0) reuse[wbank] <= reuse_in;
            if (waddr == LAST_ADDR) begin
               waddr <= '0;
               wbank <= bank_inc(wbank);
            end else begin
               waddr <= waddr + 1'b1;
            end
         end

         if (rd_fire) begin
            if (raddr == LAST_ADDR) begin
               raddr <= '0;
               if (rd_bank_done) begin
                  pass  <= '0;
                  rbank <= bank_inc(rbank);
               end else begin
                  pass  <= pass + 1'b1;
               end
            end else begin
               raddr <= raddr + 1'b1;
            end
         end

         // Completion and free in the same cycle cancel out.
         case ({bank_fill, bank_free})
            2'b10:   occupancy <= occupancy + 1'b1;
            2'b01:   occupancy <= occupancy - 1'b1;
            default: occupancy <= occupancy;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Storage
   // ---------------------------------------------------------------------------
   // NOTE: the data array has no reset; validity is tracked by bank state, so
   // clearing the words would only cost reset fan-out.
   always_ff @(posedge clk) begin
      if (wr_fire && !flush) mem[wbank][waddr] <= wr_data;
   end

endmodule

// File: doc/nbank_pingpong_buffer.md
Name: nbank_pingpong_buffer

Overview:
- Generalised successor to the two-bank west/north ping-pong buffers in the matmul datapath. It provides NUM_BANKS round-robin banks of DEPTH words each.
- The producer fills one bank while the consumer drains a completed bank.
- Each bank can be replayed a per-bank number of times before it is freed. This covers north-style operand reuse across output rows.
- The buffer sits between a linear-projection output and a systolic core-array input.

Parameters:
- DATA_WIDTH, 256, width of one stored word (e.g. WIDTH*CHUNK_SIZE*NUM_CORES).
- DEPTH, 16, words per bank (must be >= 2).
- NUM_BANKS, 2, number of banks (must be >= 2).
- MAX_REUSE, 8, maximum replay passes per bank.
- ADDR_W, $clog2(DEPTH), word address width (localparam).
- REUSE_W, $clog2(MAX_REUSE+1), reuse field width (localparam).
- OCC_W, $clog2(NUM_BANKS+1), occupancy width (localparam).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear of all bank state and pointers.
- cfg_reuse  in  REUSE_W  pass count for the bank being written; sampled with word 0 of each bank.
- wr_valid  in  1  write word valid.
- wr_ready  out  1  buffer can accept a write word.
- wr_data  in  DATA_WIDTH  write word.
- rd_valid  out  1  rd_data is valid.
- rd_ready  in  1  consumer accepts rd_data.
- rd_data  out  DATA_WIDTH  read word.
- rd_addr  out  ADDR_W  word index of rd_data within its bank.
- rd_last  out  1  rd_data is the last word of the current pass.
- rd_bank_done  out  1  rd_data is the last word of the final pass; the bank is freed on this transfer.
- occupancy  out  OCC_W  number of banks in the FULL state.

Behaviour:
- Reset (rst=1, asynchronous) and flush (synchronous): all banks EMPTY; write bank, write address, read bank, read address and pass counter all 0.
  - Outputs: wr_ready=1, rd_valid=0, rd_last=0, rd_bank_done=0, occupancy=0, rd_addr=0.
  - Memory contents are not cleared.
- Bank states are EMPTY -> FILLING -> FULL -> EMPTY, plus one per-bank reuse register.
- Write side:
  - A write transfer occurs when wr_valid && wr_ready.
  - wr_ready = state[wbank] is EMPTY or FILLING.
  - On word 0 of a bank:
    - Latch reuse[wbank] = (cfg_reuse==0) ? 1 : min(cfg_reuse, MAX_REUSE).
    - The bank goes to FILLING.
  - On word DEPTH-1: the bank goes to FULL, waddr wraps to 0 and wbank advances by (wbank+1) mod NUM_BANKS.
- Read side:
  - rd_valid = state[rbank] is FULL.
  - rd_data = mem[rbank][raddr], read combinationally. Data is visible in the same cycle as rd_valid; there is no added latency.
  - rd_addr = raddr.
  - rd_last = rd_valid && raddr==DEPTH-1.
  - rd_bank_done = rd_last && pass==reuse[rbank]-1.
  - A read transfer occurs when rd_valid && rd_ready, and increments raddr.
  - At raddr==DEPTH-1:
    - raddr wraps to 0 and pass increments.
    - On the final pass, pass goes to 0, the bank goes to EMPTY and rbank advances modulo NUM_BANKS.
  - rd_valid and rd_data stay stable while rd_valid && !rd_ready.
- Fill-to-drain latency: the last write word lands on edge N; rd_valid=1 from edge N onward, i.e. in the cycle after the last write transfer.
- Simultaneous events:
  - The final read of bank k and a write into bank k in the same cycle cannot occur, because bank k is FULL so wr_ready=0.
  - A write that completes bank j and a read that frees bank k in the same cycle both take effect; occupancy stays unchanged.
  - Write and read of different banks in the same cycle are independent.
- Buffer full (all banks FULL): wr_ready=0 and wr_data is ignored. Occupancy equals NUM_BANKS.
- Buffer empty: rd_valid=0; rd_ready is ignored.
- Occupancy update: +1 on bank completion, -1 on bank free, net 0 when both happen in the same cycle. It is registered and reflects state after the edge.
- flush has priority over any simultaneous write or read transfer in the same cycle.
- Asserting rst mid-operation discards any partially filled bank and any partially replayed bank.

Test Plan:
- Basic ping-pong (DEPTH=4, NUM_BANKS=2, cfg_reuse=1):
  - Stimulus: write 0x10..0x13 into bank 0, then 0x20..0x23 into bank 1, with rd_ready=1 throughout.
  - Required: read stream 0x10..0x13 then 0x20..0x23; rd_last and rd_bank_done asserted on 0x13 and 0x23; rd_valid asserts in the cycle after the 0x13 write.
- Reuse replay:
  - Stimulus: cfg_reuse=3, write 0xA0..0xA3.
  - Required: reads 0xA0..0xA3 three times; rd_last asserts 3 times; rd_bank_done only on the third 0xA3; occupancy 1 -> 0 after that transfer.
- Full backpressure:
  - Stimulus: rd_ready=0, write 9 words.
  - Required: wr_ready=0 after word 8; the 9th word is not accepted; occupancy=2; after one bank is freed, the 9th word is accepted into bank 0.
- Simultaneous complete and free:
  - Stimulus: align the write of word 3 of bank 1 with the rd_bank_done transfer of bank 0.
  - Required: occupancy stays 1; the next rd_valid shows bank 1 word 0.
- Read stall:
  - Stimulus: toggle rd_ready 1,0,0,1 during a drain.
  - Required: rd_data and rd_addr hold during the stall; no word is skipped or duplicated.
- Reset and flush mid-fill:
  - Stimulus: write 2 words, assert rst asynchronously mid-cycle; repeat with flush=1 for one cycle.
  - Required: outputs return to their reset values immediately on rst (on the next edge for flush); the subsequent fill starts at bank 0, address 0; cfg_reuse=0 behaves as reuse 1.
